// File: rtl/twiddle_mul_stage4.sv
// Pipelined complex twiddle multiplier for one MDC stage of the 32-point FFT.
// A sample counter produces the 2-bit W32 quadrant index, the sample is
// multiplied by the Q1.7 twiddle, then rounded and saturated back to DATA_W.
//
// Handshake: streaming with no backpressure. din_valid qualifies din_r/din_i
// in the cycle it is high; dout_valid qualifies dout_r/dout_i/tw_idx_out
// exactly 3 cycles later. There is no ready signal; every valid input is
// accepted and every valid output must be consumed in its cycle.
module twiddle_mul_stage4 #(
  parameter int DATA_W = 16,
  parameter int HOLD   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic                     frame_start,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i,
  output logic [1:0]               tw_idx_out
);

  localparam int FRAME = 4 * HOLD;
  localparam int CNT_W = $clog2(FRAME);
  localparam int PW    = DATA_W + 9;   // full-precision product width
  localparam int SW    = DATA_W + 10;  // sum/difference width
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  // Sample counter and twiddle selection
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [1:0]       idx;
  logic signed [8:0] wr, wi;

  // Stage 1 registers
  logic                     v1_q;
  logic signed [DATA_W-1:0] a1_q, b1_q;
  logic signed [8:0]        wr1_q, wi1_q;
  logic [1:0]               idx1_q;

  // Stage 2 registers
  logic                 v2_q;
  logic signed [PW-1:0] p_ar_q, p_bi_q, p_ai_q, p_br_q;
  logic [1:0]           idx2_q;

  // Stage 3 combinational path
  logic signed [SW-1:0]     re_s, im_s, re_sh, im_sh;
  logic signed [DATA_W-1:0] re_sat, im_sat;

  // Output registers
  logic                     dout_valid_q;
  logic signed [DATA_W-1:0] dout_r_q, dout_i_q;
  logic [1:0]               tw_idx_q;

  // Clamp a shifted sum into the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [SW-1:0] v);
    logic [SW-DATA_W:0] top;
    top = v[SW-1:DATA_W-1];
    if ((&top) || !(|top)) begin
      sat_fn = v[DATA_W-1:0];
    end else if (v[SW-1]) begin
      sat_fn = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_fn = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // Count the sample position; frame_start forces the current sample to slot 0.
  always_comb begin
    cnt_cur = (din_valid && frame_start) ? '0 : cnt_q;
    idx     = cnt_cur[CNT_W-1 -: 2];
    cnt_d   = cnt_q;
    if (din_valid) begin
      cnt_d = (cnt_cur == CNT_LAST) ? '0 : cnt_cur + CNT_W'(1);
    end
  end

  // Quadrant ROM: W = exp(-j*2*pi*k/8) in Q1.7.
  always_comb begin
    wr = 9'sd128;
    wi = 9'sd0;
    case (idx)
      2'd0: begin wr = 9'sd128;  wi = 9'sd0;    end
      2'd1: begin wr = 9'sd90;   wi = -9'sd90;  end
      2'd2: begin wr = 9'sd0;    wi = -9'sd128; end
      2'd3: begin wr = -9'sd90;  wi = -9'sd90;  end
      default: begin wr = 9'sd128; wi = 9'sd0; end
    endcase
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // S1: capture the sample together with its twiddle and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      wr1_q  <= '0;
      wi1_q  <= '0;
      idx1_q <= '0;
    end else begin
      v1_q   <= din_valid;
      a1_q   <= din_r;
      b1_q   <= din_i;
      wr1_q  <= wr;
      wi1_q  <= wi;
      idx1_q <= idx;
    end
  end

  // S2: four full-precision partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      p_ar_q <= '0;
      p_bi_q <= '0;
      p_ai_q <= '0;
      p_br_q <= '0;
      idx2_q <= '0;
    end else begin
      v2_q   <= v1_q;
      p_ar_q <= PW'(a1_q) * PW'(wr1_q);
      p_bi_q <= PW'(b1_q) * PW'(wi1_q);
      p_ai_q <= PW'(a1_q) * PW'(wi1_q);
      p_br_q <= PW'(b1_q) * PW'(wr1_q);
      idx2_q <= idx1_q;
    end
  end

  // S3 datapath: combine, round half up at bit 6, drop 7 fraction bits, saturate.
  always_comb begin
    re_s   = SW'(p_ar_q) - SW'(p_bi_q);
    im_s   = SW'(p_ai_q) + SW'(p_br_q);
    re_sh  = (re_s + SW'(64)) >>> 7;
    im_sh  = (im_s + SW'(64)) >>> 7;
    re_sat = sat_fn(re_sh);
    im_sat = sat_fn(im_sh);
  end

  // S3: register the final result and its aligned index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
      tw_idx_q     <= '0;
    end else begin
      dout_valid_q <= v2_q;
      dout_r_q     <= re_sat;
      dout_i_q     <= im_sat;
      tw_idx_q     <= idx2_q;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_r     = dout_r_q;
  assign dout_i     = dout_i_q;
  assign tw_idx_out = tw_idx_q;

endmodule

// File: doc/twiddle_mul_stage4.md
Name: twiddle_mul_stage4

Overview:
Pipelined complex twiddle multiplier between the radix-2 butterfly of one MDC stage and the next stage's delay commutator in the 32-point FFT. It generates the 2-bit twiddle index for the 4-entry W32 quadrant ROM. It multiplies each incoming complex sample by the indexed Q1.7 twiddle, then rounds and saturates the result back to data width. Streaming, one sample per clock, with a valid qualifier and no backpressure.

Parameters:
DATA_W, 16, signed width of each real/imag data component in and out.
HOLD, 4, consecutive valid samples per twiddle index (power of 2, >=1); one frame = 4*HOLD valid samples.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
din_valid  input  1  din_r/din_i carry a sample this cycle.
frame_start  input  1  with din_valid: this sample is sample 0 of a frame; ignored when din_valid=0.
din_r  input  DATA_W  signed real part.
din_i  input  DATA_W  signed imaginary part.
dout_valid  output  1  dout_r/dout_i valid.
dout_r  output  DATA_W  signed real result.
dout_i  output  DATA_W  signed imaginary result.
tw_idx_out  output  2  twiddle index used for the sample on dout, for debug/alignment.

Behaviour:
- Reset: async on rst_n=0. Every pipeline valid bit is 0, all data registers are 0, sample counter is 0. Outputs: dout_valid=0, dout_r=0, dout_i=0, tw_idx_out=0. Release is synchronous to clk.
- Sample counter cnt: width log2(4*HOLD). It increments by 1 on each din_valid cycle and wraps at 4*HOLD-1 -> 0. It holds when din_valid=0.
- Twiddle index: idx = cnt / HOLD, using the top 2 bits of the count.
- Frame start: if din_valid and frame_start, the sample uses cnt=0 (idx=0), and cnt becomes 1 next cycle (0 if 4*HOLD=1). This overrides any count in progress.
- Twiddle table, Q1.7 signed 9-bit (128 = 1.0), W = exp(-j*2*pi*k/8) for k = 0..3:
  - idx0 = (128, 0)
  - idx1 = (90, -90)
  - idx2 = (0, -128)
  - idx3 = (-90, -90)
  - The table is combinational from idx.
- Pipeline, fixed latency 3 cycles from din_valid to dout_valid, no bubbles inserted:
  - S1: register din, idx, and twiddle (wr, wi).
  - S2: register the four products a*wr, b*wi, a*wi, b*wr. Each is DATA_W+9 bits, full precision.
  - S3: re = a*wr - b*wi, im = a*wi + b*wr, DATA_W+10 bits. Round by adding 64, then arithmetic shift right 7. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Register to dout.
- Valid bits shift with the data. Data registers may update on invalid cycles, but dout_r/dout_i are only meaningful when dout_valid=1.
- tw_idx_out is delayed alongside the data.
- Gaps in din_valid: the output shows identical gaps 3 cycles later, and the counter does not advance during gaps.
- Back-to-back frames: the wrap from 4*HOLD-1 to 0 without frame_start is legal and continuous.
- Reset mid-stream: in-flight samples are discarded, with no spurious dout_valid after release.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream -> dout_valid=0, dout_r=dout_i=0, tw_idx_out=0 immediately (asynchronously); no dout_valid for 3 cycles after release without input.
- Unity twiddle: frame_start+din=(1000,500) at idx0 -> 3 cycles later dout=(1000,500), tw_idx_out=0.
- Index sequencing: 16 consecutive valid samples of (1000,500) from frame_start, HOLD=4 ->
  - outputs 0-3: (1000,500)
  - outputs 4-7: (1055,-352)
  - outputs 8-11: (500,-1000)
  - outputs 12-15: (-352,-1055)
  - tw_idx_out goes 0,1,2,3 in groups of four.
- Saturation: din=(-32768,-32768) at idx2 -> dout=(-32768,32767).
- Valid gaps/resync:
  - Insert 2 idle cycles after sample 5 -> output gap matches, and sample 6 still uses idx1.
  - Assert frame_start on sample 9 -> that sample uses idx0 and the count restarts.
- Wrap: 20 valid samples with a single frame_start -> samples 16-19 use idx0 again.
